// File: rtl/prefetch_unit_if.sv
// Instruction-memory port of the prefetch unit: pipelined request/grant with
// in-order read responses.
interface prefetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rvalid;
    logic [31:0]           rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/prefetch_unit.sv
// Pipelined instruction prefetcher: credit-limited word fetches into a small
// FIFO, with 16/32-bit realignment toward decode and flush-on-redirect.
module prefetch_unit #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR      = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] target_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_compressed_o,
    prefetch_unit_if.master       imem
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] RESET_WORD = {RESET_ADDR[ADDR_WIDTH-1:2], 2'b00};

    logic                  run_q, run_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d;
    logic                  half_q, half_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic [OW-1:0]         discard_q, discard_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [31:0]           mem_q [DEPTH];

    logic [31:0] head_word, next_word;
    logic [31:0] raw_instr;
    logic        raw_valid, raw_compressed;
    logic        req, grant, rsp, fire, pop, push, credit_ok;
    logic        unused_ok;

    assign head_word = mem_q[rd_ptr_q];
    assign next_word = mem_q[rd_ptr_q + PW'(1)];
    assign unused_ok = ^{target_addr_i[0], next_word[31:16]};

    // Realignment is purely a function of registered state, so decode sees
    // stable outputs while it stalls.
    always_comb begin
        raw_instr      = head_word;
        raw_compressed = 1'b0;
        raw_valid      = 1'b0;
        if (!half_q) begin
            if (head_word[1:0] != 2'b11) begin
                raw_instr      = {16'h0000, head_word[15:0]};
                raw_compressed = 1'b1;
            end
            raw_valid = (occ_q != '0);
        end else if (head_word[17:16] != 2'b11) begin
            raw_instr      = {16'h0000, head_word[31:16]};
            raw_compressed = 1'b1;
            raw_valid      = (occ_q != '0);
        end else begin
            raw_instr = {next_word[15:0], head_word[31:16]};
            raw_valid = (occ_q >= CW'(2));
        end
    end

    assign instr_valid_o      = raw_valid;
    assign instr_o            = raw_valid ? raw_instr : 32'h0;
    assign instr_compressed_o = raw_valid & raw_compressed;
    assign instr_addr_o       = head_addr_q + ADDR_WIDTH'({half_q, 1'b0});

    // Words buffered plus words in flight never exceed the FIFO size.
    assign credit_ok = (32'(occ_q) + 32'(outstanding_q)) < 32'(DEPTH);
    assign req       = run_q & ~flush_i & (32'(outstanding_q) < 32'(MAX_OUTSTANDING)) & credit_ok;
    assign imem.req  = req;
    assign imem.addr = fetch_addr_q;

    always_comb begin
        rsp   = imem.rvalid & (outstanding_q != '0);
        grant = req & imem.gnt;
        fire  = raw_valid & instr_ready_i & ~flush_i;
        pop   = fire & (~raw_compressed | half_q);
        push  = rsp & ~flush_i & (discard_q == '0);

        run_d         = 1'b1;
        fetch_addr_d  = fetch_addr_q;
        head_addr_d   = head_addr_q;
        half_d        = half_q;
        occ_d         = occ_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (flush_i) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_addr_d  = {target_addr_i[ADDR_WIDTH-1:2], 2'b00};
            head_addr_d   = {target_addr_i[ADDR_WIDTH-1:2], 2'b00};
            half_d        = target_addr_i[1];
            occ_d         = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            outstanding_d = outstanding_q - OW'(rsp);
            discard_d     = outstanding_q - OW'(rsp);
        end else begin
            if (grant) begin
                fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(4);
            end
            outstanding_d = outstanding_q + OW'(grant) - OW'(rsp);
            if (rsp && discard_q != '0) begin
                discard_d = discard_q - OW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PW'(1);
                head_addr_d = head_addr_q + ADDR_WIDTH'(4);
            end
            if (fire && raw_compressed) begin
                half_d = ~half_q;
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            fetch_addr_q  <= RESET_WORD;
            head_addr_q   <= RESET_WORD;
            half_q        <= RESET_ADDR[1];
            occ_q         <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            run_q         <= run_d;
            fetch_addr_q  <= fetch_addr_d;
            head_addr_q   <= head_addr_d;
            half_q        <= half_d;
            occ_q         <= occ_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage carries no reset; occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= imem.rdata;
        end
    end
endmodule
